play_timer: RTL and testbench

Parametrised successor to the fixed-rate minute/second playback counter in the MP3 player top level. It counts elapsed play time per song in packed BCD (mm…m:ss) and drives the seven-segment display directly, which removes the `minute*100+second` multiply. Additions: pause freeze, configurable minute-digit count, sticky saturation, a one-second strobe, and a binary elapsed-seconds count. It sits beside `bluetooth` and `mp3`, taking their pause, next, prev and finish indications.

---
 rtl/play_timer.sv | 86 ++++++++
 tb/tb_play_timer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/play_timer.sv
// Per-song playback timer: packed-BCD mm..m:ss display value, binary elapsed seconds,
// one-second strobe and sticky saturation, with pause freeze and restart on track change.
module play_timer #(
    parameter int unsigned TICK_CYCLES = 100_000_000,
    parameter int unsigned MIN_DIGITS  = 2,
    parameter int unsigned ELAPSED_W   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_pause,
    input  logic                          i_next,
    input  logic                          i_pre,
    input  logic                          i_finish_song,
    output logic [4*(MIN_DIGITS+2)-1:0]   o_dtime,
    output logic [ELAPSED_W-1:0]          o_elapsed,
    output logic                          o_sec_tick,
    output logic                          o_sat
);

    localparam int unsigned DIGITS = MIN_DIGITS + 2;
    localparam int unsigned DW     = 4 * DIGITS;
    localparam int unsigned PW     = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

    logic [PW-1:0] presc;
    logic          restart;
    logic [DW-1:0] dtime_inc;
    logic          carry;
    logic          all_nines;
    logic          max_hit;
    logic [ELAPSED_W-1:0] elapsed_inc;

    assign restart = i_next | i_pre | i_finish_song;

    // BCD ripple increment; digit 1 is sec-tens (0-5), all others 0-9
    always_comb begin
        dtime_inc = o_dtime;
        carry     = 1'b1;
        all_nines = 1'b1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (carry) begin
                if (o_dtime[4*k +: 4] == ((k == 1) ? 4'd5 : 4'd9)) begin
                    dtime_inc[4*k +: 4] = 4'd0;
                end else begin
                    dtime_inc[4*k +: 4] = o_dtime[4*k +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (k >= 2 && o_dtime[4*k +: 4] != 4'd9) begin
                all_nines = 1'b0;
            end
        end
        // the increment from x..x:58 with all minutes at 9 lands on the maximum value
        max_hit = all_nines && (o_dtime[7:0] == 8'h58);
    end

    assign elapsed_inc = (o_elapsed == {ELAPSED_W{1'b1}}) ? o_elapsed
                                                          : o_elapsed + ELAPSED_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            presc      <= '0;
            o_dtime    <= '0;
            o_elapsed  <= '0;
            o_sec_tick <= 1'b0;
            o_sat      <= 1'b0;
        end else if (i_pause) begin
            o_sec_tick <= 1'b0;
        end else if (presc != PRESC_LAST) begin
            presc      <= presc + PW'(1);
            o_sec_tick <= 1'b0;
        end else begin
            presc <= '0;
            // once saturated the prescaler keeps cycling but nothing else moves
            if (o_sat) begin
                o_sec_tick <= 1'b0;
            end else begin
                o_sec_tick <= 1'b1;
                o_dtime    <= dtime_inc;
                o_elapsed  <= elapsed_inc;
                o_sat      <= max_hit;
            end
        end
    end

endmodule

// File: tb/tb_play_timer.sv
// Self-checking bench for play_timer: directed scenarios plus randomized pause/restart
// traffic against a seconds-based reference model, on 2- and 1-minute-digit instances.
module tb_play_timer;

    localparam int T    = 4;
    localparam int MAX2 = 99 * 60 + 59;
    localparam int MAX1 = 9 * 60 + 59;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, i_pause, i_next, i_pre, i_finish_song;
    logic [15:0] dtime2;
    logic [11:0] dtime1;
    logic [15:0] el2, el1;
    logic        tick2, tick1, sat2, sat1;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: prescaler phase and elapsed whole seconds per instance
    int   m_phase = 0;
    int   m_secs2 = 0;
    int   m_secs1 = 0;
    logic m_tick2 = 1'b0;
    logic m_tick1 = 1'b0;

    play_timer #(.TICK_CYCLES(T), .MIN_DIGITS(2), .ELAPSED_W(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_pause(i_pause), .i_next(i_next), .i_pre(i_pre),
        .i_finish_song(i_finish_song), .o_dtime(dtime2), .o_elapsed(el2),
        .o_sec_tick(tick2), .o_sat(sat2));

    play_timer #(.TICK_CYCLES(T), .MIN_DIGITS(1), .ELAPSED_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_pause(i_pause), .i_next(i_next), .i_pre(i_pre),
        .i_finish_song(i_finish_song), .o_dtime(dtime1), .o_elapsed(el1),
        .o_sec_tick(tick1), .o_sat(sat1));

    function automatic logic [15:0] exp_dtime(input int s);
        int m, sc;
        m  = s / 60;
        sc = s % 60;
        return {4'((m / 10) % 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    // drive one edge's inputs, advance the model at the edge, return 1 unit after it
    task automatic step(input logic r, input logic p, input logic nx, input logic pr,
                        input logic fs);
        rst_n = r; i_pause = p; i_next = nx; i_pre = pr; i_finish_song = fs;
        @(posedge clk);
        if (!r || nx || pr || fs) begin
            m_phase = 0; m_secs2 = 0; m_secs1 = 0; m_tick2 = 1'b0; m_tick1 = 1'b0;
        end else if (p) begin
            m_tick2 = 1'b0; m_tick1 = 1'b0;
        end else if (m_phase != T - 1) begin
            m_phase++; m_tick2 = 1'b0; m_tick1 = 1'b0;
        end else begin
            m_phase = 0;
            m_tick2 = (m_secs2 != MAX2);
            if (m_tick2) m_secs2++;
            m_tick1 = (m_secs1 != MAX1);
            if (m_tick1) m_secs1++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        int first;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(28);
        n_checks++;
        if (dtime2 !== 16'h0007 || el2 !== 16'd7) begin
            n_fail++; $display("FAIL reset_precount dtime=%h el=%0d exp 0007/7", dtime2, el2);
        end
        idle(2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dtime2 !== 16'h0 || el2 !== 16'd0 || tick2 !== 1'b0 || sat2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_clear dtime=%h el=%0d tick=%b sat=%b exp all 0",
                               dtime2, el2, tick2, sat2);
        end
        n_checks++;
        if (dtime1 !== 12'h0 || el1 !== 16'd0 || tick1 !== 1'b0 || sat1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_clear_md1 dtime=%h el=%0d tick=%b sat=%b exp all 0",
                               dtime1, el1, tick1, sat1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            idle(1);
            if (tick2) begin first = i; break; end
        end
        n_checks++;
        if (first != T || dtime2 !== 16'h0001) begin
            n_fail++; $display("FAIL reset_first_tick edge=%0d dtime=%h exp %0d/0001",
                               first, dtime2, T);
        end
    endtask

    task automatic test_rollover();
        int ticks;
        ticks = 0;
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= 240; e++) begin
            idle(1);
            if (tick2) begin
                ticks++;
                if (el2 == 16'd9 || el2 == 16'd10 || el2 == 16'd59 || el2 == 16'd60) begin
                    logic [15:0] exp;
                    exp = (el2 == 16'd9)  ? 16'h0009 : (el2 == 16'd10) ? 16'h0010 :
                          (el2 == 16'd59) ? 16'h0059 : 16'h0100;
                    n_checks++;
                    if (dtime2 !== exp) begin
                        n_fail++; $display("FAIL rollover_step el=%0d dtime=%h exp %h",
                                           el2, dtime2, exp);
                    end
                end
            end
        end
        n_checks++;
        if (dtime2 !== 16'h0100 || el2 !== 16'd60 || ticks != 60) begin
            n_fail++; $display("FAIL rollover_end dtime=%h el=%0d ticks=%0d exp 0100/60/60",
                               dtime2, el2, ticks);
        end
        n_checks++;
        if (dtime1 !== 12'h100) begin
            n_fail++; $display("FAIL rollover_md1 dtime=%h exp 100", dtime1);
        end
    endtask

    task automatic test_pause();
        int n;
        logic bad;
        bad = 1'b0;
        idle(2);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            if (tick2 !== 1'b0 || dtime2 !== 16'h0100) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL pause_hold tick=%b dtime=%h exp 0/0100", tick2, dtime2);
        end
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            idle(1);
            if (tick2) begin n = i; break; end
        end
        n_checks++;
        if (n != 2 || dtime2 !== 16'h0101) begin
            n_fail++; $display("FAIL pause_resume edges=%0d dtime=%h exp 2/0101", n, dtime2);
        end
    endtask

    task automatic test_restart_collision();
        int n;
        for (int v = 0; v < 4; v++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            idle(20);
            n_checks++;
            if (dtime2 !== 16'h0005) begin
                n_fail++; $display("FAIL collide_setup v=%0d dtime=%h exp 0005", v, dtime2);
            end
            idle(T - 1);
            step(1'b1, v == 3, v == 1, v == 0 || v == 3, v == 2);
            n_checks++;
            if (dtime2 !== 16'h0 || tick2 !== 1'b0 || el2 !== 16'd0) begin
                n_fail++; $display("FAIL collide_clear v=%0d dtime=%h tick=%b el=%0d exp 0/0/0",
                                   v, dtime2, tick2, el2);
            end
            n = 0;
            for (int i = 1; i <= 10; i++) begin
                idle(1);
                if (tick2) begin n = i; break; end
            end
            n_checks++;
            if (n != T || dtime2 !== 16'h0001) begin
                n_fail++; $display("FAIL collide_next v=%0d edges=%0d dtime=%h exp %0d/0001",
                                   v, n, dtime2, T);
            end
        end
    endtask

    task automatic test_saturation();
        logic saw;
        int   ticks;
        saw = 1'b0;
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= 600 * T; e++) begin
            idle(1);
            if (tick1 && el1 == 16'd598) begin
                n_checks++;
                if (sat1 !== 1'b0) begin
                    n_fail++; $display("FAIL sat_early sat=%b at 598 exp 0", sat1);
                end
            end
            if (tick1 && el1 == 16'd599) begin
                saw = 1'b1;
                n_checks++;
                if (sat1 !== 1'b1 || dtime1 !== 12'h959) begin
                    n_fail++; $display("FAIL sat_hit sat=%b dtime=%h exp 1/959", sat1, dtime1);
                end
            end
        end
        n_checks++;
        if (!saw) begin
            n_fail++; $display("FAIL sat_reached seen=%b exp 1", saw);
        end
        ticks = 0;
        for (int e = 0; e < 20 * T; e++) begin
            idle(1);
            if (tick1) ticks++;
        end
        n_checks++;
        if (ticks != 0 || dtime1 !== 12'h959 || el1 !== 16'd599 || sat1 !== 1'b1) begin
            n_fail++; $display("FAIL sat_hold ticks=%0d dtime=%h el=%0d sat=%b exp 0/959/599/1",
                               ticks, dtime1, el1, sat1);
        end
        n_checks++;
        if (dtime2 !== 16'h1020 || el2 !== 16'd620 || sat2 !== 1'b0) begin
            n_fail++; $display("FAIL sat_md2_run dtime=%h el=%0d sat=%b exp 1020/620/0",
                               dtime2, el2, sat2);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (dtime1 !== 12'h0 || el1 !== 16'd0 || sat1 !== 1'b0) begin
            n_fail++; $display("FAIL sat_restart dtime=%h el=%0d sat=%b exp 0/0/0",
                               dtime1, el1, sat1);
        end
    endtask

    task automatic test_random();
        logic p;
        logic [15:0] e2, e1;
        p = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            logic r, nx, pr, fs, bad;
            int   secs;
            if ($urandom_range(0, 19) == 0) p = ~p;
            r  = ($urandom_range(0, 1999) != 0);
            nx = ($urandom_range(0, 1499) == 0);
            pr = ($urandom_range(0, 1499) == 0);
            fs = ($urandom_range(0, 1499) == 0);
            step(r, p, nx, pr, fs);
            e2 = exp_dtime(m_secs2);
            e1 = exp_dtime(m_secs1);
            n_checks++;
            if (dtime2 !== e2 || el2 !== 16'(m_secs2) || tick2 !== m_tick2 ||
                sat2 !== (m_secs2 == MAX2)) begin
                n_fail++; $display("FAIL rand_md2 c=%0d dtime=%h el=%0d tick=%b sat=%b exp %h/%0d/%b/%b",
                                   c, dtime2, el2, tick2, sat2, e2, m_secs2, m_tick2, m_secs2 == MAX2);
            end
            n_checks++;
            if (dtime1 !== e1[11:0] || el1 !== 16'(m_secs1) || tick1 !== m_tick1 ||
                sat1 !== (m_secs1 == MAX1)) begin
                n_fail++; $display("FAIL rand_md1 c=%0d dtime=%h el=%0d tick=%b sat=%b exp %h/%0d/%b/%b",
                                   c, dtime1, el1, tick1, sat1, e1[11:0], m_secs1, m_tick1, m_secs1 == MAX1);
            end
            bad = (dtime2[7:4] > 4'd5);
            for (int k = 0; k < 4; k++) if (dtime2[4*k +: 4] > 4'd9) bad = 1'b1;
            secs = (int'(dtime2[15:12]) * 10 + int'(dtime2[11:8])) * 60 +
                   int'(dtime2[7:4]) * 10 + int'(dtime2[3:0]);
            n_checks++;
            if (bad || secs != int'(el2)) begin
                n_fail++; $display("FAIL rand_invariant c=%0d dtime=%h el=%0d bcd_secs=%0d",
                                   c, dtime2, el2, secs);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; i_pause = 1'b0; i_next = 1'b0; i_pre = 1'b0; i_finish_song = 1'b0;
        test_reset();
        test_rollover();
        test_pause();
        test_restart_collision();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
